i2s_rx: RTL and testbench

- I2S receiver (Philips format) that deserialises SDATA into parallel left/right words, sampling on SCLK rising edges.
- It is the mirror of the I2S transmitter: both sit on the same SCLK/LRCK pair, and the receiver feeds the DSP datapath from an external ADC or a loopback.
- Completed stereo frames are presented as a parallel pair with a one-cycle valid strobe.

---
 rtl/i2s_rx.sv | 103 ++++++++++
 tb/tb_i2s_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - Philips I2S receiver: SDATA to parallel left/right pair with one-cycle valid.
// Optional slot-length error pulse on len_err_out when I2S_RX_LEN_CHECK_EN is defined.
module i2s_rx #(
    parameter int PDATA_WIDTH = 32
) (
    input  logic                   sclk_in,
    input  logic                   rst_in,
    input  logic                   lrck_in,
    input  logic                   sdata_in,
    output logic [PDATA_WIDTH-1:0] pldata_out,
    output logic [PDATA_WIDTH-1:0] prdata_out,
    output logic                   valid_out,
    output logic                   len_err_out
);

    localparam int CW = $clog2(PDATA_WIDTH + 2);

    typedef enum logic {
        SYNC,
        RUN
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   lrck_d1;
    logic                   edge_det;
    logic [PDATA_WIDTH-1:0] asm_q;
    logic [PDATA_WIDTH-1:0] word_now;
    logic [PDATA_WIDTH-1:0] left_hold;
    logic [CW-1:0]          bit_cnt;
    logic                   left_ok;

    // word_now is the slot word with the bit on the wire merged in; bits past the word width fall off
    always_comb begin
        edge_det = lrck_in ^ lrck_d1;
        state_d  = state_q;
        word_now = asm_q;
        case (state_q)
            SYNC:    if (edge_det) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = SYNC;
        endcase
        for (int i = 0; i < PDATA_WIDTH; i++) begin
            if (bit_cnt == CW'(PDATA_WIDTH - 1 - i)) word_now[i] = sdata_in;
        end
    end

`ifdef I2S_RX_LEN_CHECK_EN
    logic len_err_q;
    assign len_err_out = len_err_q;
`else
    assign len_err_out = 1'b0;
`endif

    always_ff @(posedge sclk_in) begin
        if (rst_in) begin
            state_q    <= SYNC;
            lrck_d1    <= 1'b0;
            asm_q      <= '0;
            bit_cnt    <= '0;
            left_hold  <= '0;
            left_ok    <= 1'b0;
            pldata_out <= '0;
            prdata_out <= '0;
            valid_out  <= 1'b0;
`ifdef I2S_RX_LEN_CHECK_EN
            len_err_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            lrck_d1   <= lrck_in;
            valid_out <= 1'b0;
`ifdef I2S_RX_LEN_CHECK_EN
            len_err_q <= 1'b0;
`endif
            if (edge_det) begin
                // The edge bit closes the old slot; the next posedge carries the new MSB
                asm_q   <= '0;
                bit_cnt <= '0;
                if (state_q == RUN) begin
`ifdef I2S_RX_LEN_CHECK_EN
                    len_err_q <= (bit_cnt != CW'(PDATA_WIDTH - 1));
`endif
                    if (!lrck_d1) begin
                        left_hold <= word_now;
                        left_ok   <= 1'b1;
                    end else if (left_ok) begin
                        pldata_out <= left_hold;
                        prdata_out <= word_now;
                        valid_out  <= 1'b1;
                        left_ok    <= 1'b0;
                    end
                end else begin
                    left_ok <= 1'b0;
                end
            end else if (state_q == RUN) begin
                asm_q <= word_now;
                if (bit_cnt != CW'(PDATA_WIDTH + 1)) bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - Randomized scoreboard bench for i2s_rx (PDATA_WIDTH=32).
module tb_i2s_rx;

    localparam int W = 32;

    logic          sclk_in = 1'b0;
    logic          rst_in;
    logic          lrck_in;
    logic          sdata_in;
    logic [W-1:0]  pldata_out;
    logic [W-1:0]  prdata_out;
    logic          valid_out;
    logic          len_err_out;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic cur_lrck = 1'b0;

    typedef struct {
        int          cyc;
        logic [31:0] l;
        logic [31:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   len_q[$];

    i2s_rx #(.PDATA_WIDTH(W)) dut (
        .sclk_in    (sclk_in),
        .rst_in     (rst_in),
        .lrck_in    (lrck_in),
        .sdata_in   (sdata_in),
        .pldata_out (pldata_out),
        .prdata_out (prdata_out),
        .valid_out  (valid_out),
        .len_err_out(len_err_out)
    );

    always #5 sclk_in = ~sclk_in;

    always @(posedge sclk_in) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output event must match the head of its expectation queue
    always @(negedge sclk_in) begin
        exp_t e;
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("valid_cycle", 32'(cyc), 32'(e.cyc));
                chk("pldata", pldata_out, e.l);
                chk("prdata", prdata_out, e.r);
            end
        end
`ifdef I2S_RX_LEN_CHECK_EN
        if (len_err_out === 1'b1) begin
            if (len_q.size() == 0) chk("unexpected_len_err", 32'd1, 32'd0);
            else chk("len_err_cycle", 32'(cyc), 32'(len_q.pop_front()));
        end
`else
        chk("len_err_zero", {31'd0, len_err_out}, 32'd0);
`endif
    end

    task automatic drive_bit(input logic lr, input logic b, output int idx);
        @(negedge sclk_in);
        rst_in   = 1'b0;
        lrck_in  = lr;
        sdata_in = b;
        cur_lrck = lr;
        idx      = cyc + 1;
    endtask

    task automatic do_reset();
        @(negedge sclk_in);
        rst_in   = 1'b1;
        lrck_in  = 1'b0;
        sdata_in = 1'b0;
        cur_lrck = 1'b0;
        @(posedge sclk_in);
        #1;
        chk("rst_pldata", pldata_out, 32'd0);
        chk("rst_prdata", prdata_out, 32'd0);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_len_err", {31'd0, len_err_out}, 32'd0);
    endtask

    // Slot 0 is the partial slot seen right after reset; then nslots full slots alternate channel.
    // fix_n == 0 selects random slot lengths (2..40) and random data.
    task automatic run_stream(input logic first_ch, input int k, input int nslots,
                              input int fix_n, input logic [63:0] ld, input logic [63:0] rd);
        logic        ch;
        int          n;
        int          idx;
        logic [63:0] d;
        logic [31:0] w;
        logic [31:0] lw;
        bit          pend;
        pend = 0;
        lw   = '0;
        for (int s = 0; s <= nslots; s++) begin
            ch = first_ch ^ s[0];
            if (s == 0) begin
                n = k;
                d = {$urandom, $urandom};
            end else if (fix_n != 0) begin
                n = fix_n;
                d = ch ? rd : ld;
            end else begin
                n = $urandom_range(2, 40);
                d = {$urandom, $urandom};
            end
            d = d & ((64'd1 << n) - 64'd1);
            idx = 0;
            for (int j = 0; j < n; j++) begin
                drive_bit((j == n - 1) ? ~ch : ch, d[n-1-j], idx);
            end
            w = (n >= W) ? 32'(d >> (n - W)) : 32'(d << (W - n));
            if (s == 0) begin
`ifdef I2S_RX_LEN_CHECK_EN
                if (ch && (n - 1) != W) len_q.push_back(idx);
`endif
            end else begin
`ifdef I2S_RX_LEN_CHECK_EN
                if (n != W) len_q.push_back(idx);
`endif
                if (!ch) begin
                    lw   = w;
                    pend = 1;
                end else if (pend) begin
                    exp_q.push_back('{cyc: idx, l: lw, r: w});
                    pend = 0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        int idx;
        for (int i = 0; i < n; i++) drive_bit(cur_lrck, 1'b0, idx);
    endtask

    initial begin
        int idx;
        rst_in   = 1'b1;
        lrck_in  = 1'b0;
        sdata_in = 1'b0;
        do_reset();
        do_reset();

        run_stream(1'b0, 10, 5, 32, 64'hA5A50001, 64'h800000FF);
        idle(3);

        do_reset();
        run_stream(1'b1, 12, 6, 32, 64'h0F0F1234, 64'h13579BDF);
        idle(3);

        do_reset();
        run_stream(1'b0, 5, 5, 24, 64'h123456, 64'hABCDEF);
        idle(3);

        do_reset();
        run_stream(1'b0, 7, 5, 34, (64'hDEADBEEF << 2) | 64'd3, (64'hDEADBEEF << 2) | 64'd1);
        idle(3);

        do_reset();
        run_stream(1'b0, 9, 5, 32, 64'hCAFE0001, 64'h0000BEEF);
        for (int i = 0; i < 5; i++) drive_bit(1'b0, 1'($urandom), idx);
        do_reset();
        run_stream(1'b0, 27, 5, 32, 64'h11223344, 64'h55667788);
        idle(3);

        for (int t = 0; t < 6; t++) begin
            do_reset();
            run_stream(1'($urandom_range(0, 1)), $urandom_range(3, 20), $urandom_range(4, 20),
                       0, 64'd0, 64'd0);
            idle(3);
        end

        idle(4);
        chk("missed_valid", 32'(exp_q.size()), 32'd0);
        chk("missed_len_err", 32'(len_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
